// File: rtl/nios_system_pio_pulse.sv
// nios_system_pio_pulse: Avalon-MM PIO with atomic set/clear, self-clearing pulse outputs and edge-capture interrupt
module nios_system_pio_pulse #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int PULSE_CYCLES = 4,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);
  localparam int CW = $clog2(PULSE_CYCLES + 1);
  logic [WIDTH-1:0] out_q, mask_q, edge_q, pmask_q, s1, s2, prev, wd, det, rd;
  logic [CW-1:0] cnt_q;
  logic wr, expire, unused_bits;
  always_comb begin
    wr = chipselect & ~write_n;
    wd = writedata[WIDTH-1:0];
    expire = cnt_q == CW'(1);
    det = EDGE_TYPE == 0 ? s2 & ~prev : EDGE_TYPE == 1 ? ~s2 & prev : s2 ^ prev;
    rd = address == 3'd0 ? out_q :
         address == 3'd1 ? s2 :
         address == 3'd2 ? mask_q :
         address == 3'd3 ? edge_q :
         address == 3'd6 ? pmask_q : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_q <= RESET_VALUE;
      mask_q <= '0;
      edge_q <= '0;
      pmask_q <= '0;
      cnt_q <= '0;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      prev <= s2;
      edge_q <= (edge_q & ~(wr && address == 3'd3 ? wd : '0)) | det;
      if (wr && address == 3'd2) mask_q <= wd;
      if (wr && address == 3'd0) begin
        out_q <= wd;
        pmask_q <= '0;
        cnt_q <= '0;
      end else if (wr && address == 3'd6) begin
        out_q <= out_q | wd;
        pmask_q <= pmask_q | wd;
        cnt_q <= CW'(PULSE_CYCLES);
      end else begin
        // expiry is applied after set/clear so a colliding OUTSET of a pulsed bit loses
        out_q <= (wr && address == 3'd4 ? out_q | wd :
                  wr && address == 3'd5 ? out_q & ~wd : out_q) & ~(expire ? pmask_q : '0);
        if (expire) pmask_q <= '0;
        if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
      end
    end
  assign readdata = 32'(rd);
  assign out_port = out_q;
  assign irq = |(edge_q & mask_q);
  assign unused_bits = ^(writedata >> WIDTH);
endmodule

// File: tb/tb_nios_system_pio_pulse.sv
// tb_nios_system_pio_pulse: directed and randomized checks against a deadline-based reference model
module tb_nios_system_pio_pulse;
  localparam int P = 4;
  logic clk = 0, reset_n = 0, chipselect = 0, write_n = 1, irq;
  logic [2:0] address = 0;
  logic [31:0] writedata = 0, readdata;
  logic [7:0] in_port = 0, out_port;
  int checks = 0, failures = 0;
  logic [7:0] m_out, m_pmask, m_mask, m_edge;
  logic [7:0] h[3];
  int cyc, m_end;

  always #5 clk = ~clk;

  nios_system_pio_pulse #(.WIDTH(8), .RESET_VALUE(8'hA5), .PULSE_CYCLES(P), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .out_port(out_port), .irq(irq));

  task automatic m_reset;
    m_out = 8'hA5; m_pmask = 0; m_mask = 0; m_edge = 0; m_end = 0; cyc = 0;
    for (int i = 0; i < 3; i++) h[i] = 0;
  endtask

  // IN is in_port two edges old; an edge event compares it with the value three edges old
  function automatic logic [7:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return m_out;
      3'd1: return h[1];
      3'd2: return m_mask;
      3'd3: return m_edge;
      3'd6: return m_pmask;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step(input bit w, input logic [2:0] a, input logic [7:0] d);
    chipselect = w | 1'($urandom_range(0, 1));
    write_n = ~w;
    address = a;
    writedata = {24'($urandom), d};
    @(posedge clk);
    cyc++;
    if (w && a == 3'd3) m_edge = m_edge & ~d;
    m_edge = m_edge | (h[1] & ~h[2]);
    h[2] = h[1]; h[1] = h[0]; h[0] = in_port;
    if (w && a == 3'd2) m_mask = d;
    if (w && a == 3'd0) begin
      m_out = d; m_pmask = 0; m_end = 0;
    end else if (w && a == 3'd6) begin
      m_out = m_out | d; m_pmask = m_pmask | d; m_end = cyc + P;
    end else begin
      if (w && a == 3'd4) m_out = m_out | d;
      if (w && a == 3'd5) m_out = m_out & ~d;
      if (m_end == cyc) begin
        m_out = m_out & ~m_pmask; m_pmask = 0; m_end = 0;
      end
    end
    #1;
    chipselect = 0;
    write_n = 1;
  endtask

  task automatic test_reset;
    logic [2:0] al[3];
    al = '{3'd2, 3'd3, 3'd6};
    m_reset();
    #12;
    checks++; if (out_port !== 8'hA5) begin failures++; $display("FAIL reset_out: got %h want a5", out_port); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
    for (int i = 0; i < 3; i++) begin
      address = al[i]; #1;
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_rd%0d: got %h want 0", al[i], readdata); end
    end
    @(negedge clk) reset_n = 1;
  endtask

  task automatic test_set_clr;
    step(1, 3'd0, 8'h0F);
    checks++; if (out_port !== 8'h0F) begin failures++; $display("FAIL out_write: got %h want 0f", out_port); end
    step(1, 3'd4, 8'h30);
    checks++; if (out_port !== 8'h3F) begin failures++; $display("FAIL outset: got %h want 3f", out_port); end
    step(1, 3'd5, 8'h03);
    checks++; if (out_port !== 8'h3C) begin failures++; $display("FAIL outclr: got %h want 3c", out_port); end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #1;
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rd_zero%0d: got %h want 0", a, readdata); end
    end
    address = 3'd0; #1;
    checks++; if (readdata !== 32'h3C) begin failures++; $display("FAIL rd_out: got %h want 3c", readdata); end
  endtask

  task automatic test_pulse;
    step(1, 3'd6, 8'h01);
    for (int i = 0; i < 5; i++) begin
      address = 3'd6; #1;
      checks++; if (out_port[0] !== (i < 4)) begin failures++; $display("FAIL pulse_bit t%0d: got %b want %b", i, out_port[0], i < 4); end
      checks++; if (readdata !== ((i < 4) ? 32'h1 : 32'h0)) begin failures++; $display("FAIL pulse_mask t%0d: got %h", i, readdata); end
      if (i < 4) step(0, 3'd0, 8'h00);
    end
  endtask

  task automatic test_retrigger;
    step(1, 3'd6, 8'h01);
    step(0, 3'd0, 8'h00);
    step(1, 3'd6, 8'h02);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_port[1:0] !== ((i < 4) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL retrig t%0d: got %b", i, out_port[1:0]); end
      if (i < 4) step(0, 3'd0, 8'h00);
    end
    step(1, 3'd6, 8'h01);
    repeat (3) step(0, 3'd0, 8'h00);
    step(1, 3'd4, 8'h01);
    checks++; if (out_port[0] !== 1'b0) begin failures++; $display("FAIL expire_vs_outset: got %b want 0", out_port[0]); end
    step(1, 3'd6, 8'h04);
    repeat (3) step(0, 3'd0, 8'h00);
    step(1, 3'd6, 8'h08);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_port[3:2] !== ((i < 4) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL expire_vs_pulse t%0d: got %b", i, out_port[3:2]); end
      if (i < 4) step(0, 3'd0, 8'h00);
    end
    step(1, 3'd6, 8'h80);
    step(0, 3'd0, 8'h00);
    step(1, 3'd0, 8'h81);
    for (int i = 0; i < 6; i++) begin
      step(0, 3'd0, 8'h00);
      checks++; if (out_port !== 8'h81) begin failures++; $display("FAIL out_cancel t%0d: got %h want 81", i, out_port); end
    end
  endtask

  task automatic test_edge_irq;
    step(1, 3'd2, 8'h04);
    in_port = 8'h04;
    step(0, 3'd0, 8'h00);
    address = 3'd3; #1;
    checks++; if (readdata !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL edge_e1: got %h irq %b want 0", readdata, irq); end
    step(0, 3'd0, 8'h00);
    address = 3'd1; #1;
    checks++; if (readdata !== 32'h04) begin failures++; $display("FAIL in_sync: got %h want 04", readdata); end
    address = 3'd3; #1;
    checks++; if (readdata !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL edge_e2: got %h irq %b want 0", readdata, irq); end
    step(0, 3'd0, 8'h00);
    address = 3'd3; #1;
    checks++; if (readdata !== 32'h04 || irq !== 1'b1) begin failures++; $display("FAIL edge_e3: got %h irq %b want 04 1", readdata, irq); end
    in_port = 8'h00;
    repeat (4) step(0, 3'd0, 8'h00);
    address = 3'd3; #1;
    checks++; if (readdata !== 32'h04) begin failures++; $display("FAIL edge_fall: got %h want 04", readdata); end
    step(1, 3'd3, 8'h04);
    address = 3'd3; #1;
    checks++; if (readdata !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL edge_w1c: got %h irq %b want 0", readdata, irq); end
  endtask

  task automatic test_async_reset;
    step(1, 3'd2, 8'hFF);
    step(1, 3'd6, 8'h10);
    in_port = 8'h01;
    repeat (3) step(0, 3'd0, 8'h00);
    #2 reset_n = 0;
    m_reset();
    #1;
    checks++; if (out_port !== 8'hA5 || irq !== 1'b0) begin failures++; $display("FAIL arst_out: got %h irq %b want a5 0", out_port, irq); end
    for (int a = 1; a < 4; a++) begin
      address = 3'(a); #1;
      checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL arst_rd%0d: got %h want 0", a, readdata); end
    end
    address = 3'd6; #1;
    checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL arst_pmask: got %h want 0", readdata); end
    in_port = 8'h00;
    @(negedge clk) reset_n = 1;
    for (int i = 0; i < 8; i++) begin
      step(0, 3'd0, 8'h00);
      checks++; if (out_port !== 8'hA5) begin failures++; $display("FAIL arst_noexp t%0d: got %h want a5", i, out_port); end
    end
  endtask

  task automatic test_random;
    logic [2:0] ra;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7)));
      checks++; if (out_port !== m_out) begin failures++; $display("FAIL rnd_out c%0d: got %h want %h", i, out_port, m_out); end
      checks++; if (irq !== |(m_edge & m_mask)) begin failures++; $display("FAIL rnd_irq c%0d: got %b want %b", i, irq, |(m_edge & m_mask)); end
      ra = 3'($urandom_range(0, 7));
      address = ra; #1;
      checks++; if (readdata !== {24'h0, m_rd(ra)}) begin failures++; $display("FAIL rnd_rd%0d c%0d: got %h want %h", ra, i, readdata, m_rd(ra)); end
    end
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_pulse();
    test_retrigger();
    test_edge_irq();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nios_system_pio_pulse.md
# nios_system_pio_pulse

Parametrised Avalon-MM parallel I/O peripheral for the Nios II watch system. It is the successor to the single-register output PIOs used for controls such as start_chrono. It provides a WIDTH-bit output register with atomic set/clear access and a self-clearing pulse mode for strobes (start/stop/lap). It also provides a synchronised input port with edge capture and a maskable interrupt, so one instance can replace a pair of separate button and strobe PIOs.

## Interface
- WIDTH, 8: width of out_port, in_port and the data bits of every register; legal range 1..32.
- RESET_VALUE, 0: value of the output register after reset; WIDTH bits.
- PULSE_CYCLES, 4: number of clocks a pulse-mode bit stays high; must be at least 1; counter width is clog2(PULSE_CYCLES+1).
- EDGE_TYPE, 0: edge-capture mode. 0 = rising, 1 = falling, 2 = any edge.
- clk  input  1  system clock; all state is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- chipselect  input  1  Avalon slave select.
- address  input  3  register index.
- write_n  input  1  active-low write strobe. A write occurs on a rising edge where chipselect=1 and write_n=0.
- writedata  input  32  write data; only bits [WIDTH-1:0] are used.
- readdata  output  32  combinational read mux of address; zero-extended above WIDTH.
- in_port  input  WIDTH  asynchronous external inputs (buttons).
- out_port  output  WIDTH  output register.
- irq  output  1  level interrupt. irq = OR of (EDGE & IRQ_MASK).

## Operation
Register map (index: access, function):
- 0 OUT: R/W. Writing loads the output register, clears the pulse mask and zeroes the pulse counter.
- 1 IN: read-only. Returns the synchronised input (second synchroniser stage).
- 2 IRQ_MASK: R/W; per-bit interrupt enable.
- 3 EDGE: R/W1C. Returns captured edges; writing 1 to a bit clears it.
- 4 OUTSET: write-only. OUT |= writedata. Pulse mask and counter are unchanged. Reads return 0.
- 5 OUTCLR: write-only. OUT &= ~writedata. Pulse mask and counter are unchanged. Reads return 0.
- 6 PULSE: write sets OUT |= writedata and pulse_mask |= writedata, and loads the counter with PULSE_CYCLES. Reads return pulse_mask.
- 7: reserved. Writes are ignored; reads return 0.

Behaviour:
- A write of zero to PULSE reloads the counter but changes no bits.
- The pulse counter runs only while non-zero. When it equals 1, the next edge does all of the following:
  - OUT &= ~pulse_mask;
  - pulse_mask = 0;
  - counter = 0.
- Retrigger: a PULSE write while the counter is non-zero merges bits and restarts the full PULSE_CYCLES window for all masked bits.
- Input path: two-flop synchroniser followed by a prev register. Per-bit edge detect from sync vs prev:
  - rise = sync & ~prev;
  - fall = ~sync & prev;
  - any = rise | fall.
- EDGE bits are sticky until cleared by a W1C write.
- The synchroniser, prev and EDGE registers do not depend on chipselect.
- Reset values:
  - OUT = RESET_VALUE;
  - IRQ_MASK, EDGE, pulse_mask and counter = 0;
  - synchroniser and prev = 0;
  - irq = 0.
- Reset asserted mid-pulse aborts the pulse and returns out_port to RESET_VALUE.

## Timing
- Register writes take effect at the write edge; out_port shows the new value in the following cycle.
- Pulse length: a PULSE write at edge k drives the bits high from edge k until edge k+PULSE_CYCLES. That is exactly PULSE_CYCLES clocks high.
- Counter expiry on the same edge as an OUTSET of a masked bit: expiry wins, and the bit is cleared.
- Counter expiry on the same edge as a PULSE write: the new PULSE write wins (merge and reload).
- in_port change is visible in IN two edges later. The matching EDGE bit sets on the third edge; irq asserts in the same cycle if the bit is masked in.
- W1C clear and a new detected edge on the same bit in the same cycle: the bit stays set.
- A write to IRQ_MASK affects irq in the cycle after the write edge. irq has no other added latency; it is combinational from registers.
- readdata is valid in the same cycle as address (zero wait states).

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_port=8'hA5, irq=0, and readdata is 0 for indices 2, 3 and 6.
- Write OUT=8'h0F, then OUTSET=8'h30, then OUTCLR=8'h03 -> out_port goes 8'h0F, 8'h3F, 8'h3C on successive cycles.
- With PULSE_CYCLES=4, write PULSE=8'h01 -> bit0 is high for exactly 4 clocks and then 0; index 6 reads 8'h01 during the pulse and 0 after.
- Pulse retrigger: write PULSE=8'h01, then PULSE=8'h02 two cycles later -> both bits clear together 4 clocks after the second write. Also, an OUT write mid-pulse cancels the auto-clear.
- With EDGE_TYPE=0, IRQ_MASK=8'h04, drive in_port bit2 0->1 -> EDGE=8'h04 on the third edge and irq=1. A falling edge adds nothing. W1C 8'h04 -> irq=0.
- Assert reset_n low mid-pulse and mid-capture -> all state returns to reset values immediately with no clock needed, and no pulse expiry follows release.
